// File: rtl/counter_sequencer_if.sv
// Bundle between a job requester / counter datapath and counter_sequencer.
// The slave side is the sequencer; the master side is the requester plus the counter feedback.
interface counter_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] target;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_en;
    logic             cnt_clr;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start,
        output target,
        output pause,
        output abort,
        output cnt_value,
        input  cnt_en,
        input  cnt_clr,
        input  busy,
        input  done,
        input  aborted
    );

    modport slave (
        input  start,
        input  target,
        input  pause,
        input  abort,
        input  cnt_value,
        output cnt_en,
        output cnt_clr,
        output busy,
        output done,
        output aborted
    );
endinterface

// File: rtl/counter_sequencer.sv
// Job controller for an external counter: clear it, then enable it for exactly
// the latched target number of cycles, with pause, abort and a start/done handshake.
module counter_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    counter_sequencer_if.slave io_bus
);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] w_target_next;
    logic             r_aborted;
    logic             w_aborted_next;
    logic             w_cnt_en;
    logic             w_last;

    // Terminal compare: the enabled cycle where the counter reads target-1 brings it to target.
    assign w_last = (io_bus.cnt_value == (r_target - WIDTH'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_target  <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_target  <= w_target_next;
            r_aborted <= w_aborted_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_target_next  = r_target;
        w_aborted_next = 1'b0;
        w_cnt_en       = 1'b0;
        unique case (r_state)
            StIdle: begin
                // A simultaneous abort is ignored here, so start always wins.
                if (io_bus.start) begin
                    w_target_next = io_bus.target;
                    w_state_next  = (io_bus.target == '0) ? StDone : StClear;
                end
            end
            StClear: begin
                if (io_bus.abort) begin
                    w_state_next   = StIdle;
                    w_aborted_next = 1'b1;
                end else begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_cnt_en = !io_bus.pause && !io_bus.abort;
                if (io_bus.abort) begin
                    w_state_next   = StIdle;
                    w_aborted_next = 1'b1;
                end else if (w_cnt_en && w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign io_bus.cnt_en  = w_cnt_en;
    assign io_bus.cnt_clr = (r_state == StClear);
    assign io_bus.busy    = (r_state == StClear) || (r_state == StRun);
    assign io_bus.done    = (r_state == StDone);
    assign io_bus.aborted = r_aborted;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer driving a behavioural 8-bit counter.
module tb_counter_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    counter_sequencer_if #(.WIDTH(8)) bus ();

    counter_sequencer #(.WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    // Stand-in for basic_counter: synchronous clear, count enable, no link to rst_n.
    logic [7:0] r_cnt = 8'd0;
    always_ff @(posedge clk) begin
        if (bus.cnt_clr)     r_cnt <= 8'd0;
        else if (bus.cnt_en) r_cnt <= r_cnt + 8'd1;
    end
    assign bus.cnt_value = r_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start for one edge; returns in cycle 1 after the accepting edge.
    task automatic kick(input logic [7:0] t);
        bus.start  = 1'b1;
        bus.target = t;
        tick();
        bus.start  = 1'b0;
        bus.target = 8'hA5;
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        rst_n      = 1'b0;
        bus.start  = 1'b1;
        bus.target = 8'd5;
        bus.pause  = 1'b0;
        bus.abort  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        outs = {bus.cnt_en, bus.cnt_clr, bus.busy, bus.done, bus.aborted};
        checks++;
        if (outs !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs, 5'b0);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();
        outs = {bus.cnt_en, bus.cnt_clr, bus.busy, bus.done, bus.aborted};
        checks++;
        if (outs !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected %b", outs, 5'b0);
        end
    endtask

    // target=3, abort raised together with start (start must win).
    task automatic test_basic();
        logic [4:0] outs, exp;
        logic [7:0] exp_val;
        bus.abort = 1'b1;
        kick(8'd3);
        bus.abort = 1'b0;
        #1;
        for (int idx = 1; idx <= 6; idx++) begin
            exp = {(idx >= 2 && idx <= 4), (idx == 1), (idx <= 4), (idx == 5), 1'b0};
            outs = {bus.cnt_en, bus.cnt_clr, bus.busy, bus.done, bus.aborted};
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL basic_outs[%0d]: got %b expected %b", idx, outs, exp);
            end
            if (idx >= 2) begin
                exp_val = (idx >= 5) ? 8'd3 : 8'(idx - 2);
                checks++;
                if (bus.cnt_value !== exp_val) begin
                    errors++;
                    $display("FAIL basic_value[%0d]: got %0d expected %0d", idx, bus.cnt_value,
                             exp_val);
                end
            end
            tick();
            #1;
        end
    endtask

    task automatic test_zero();
        logic [4:0] outs, exp;
        kick(8'd0);
        #1;
        for (int idx = 1; idx <= 2; idx++) begin
            exp  = {1'b0, 1'b0, 1'b0, (idx == 1), 1'b0};
            outs = {bus.cnt_en, bus.cnt_clr, bus.busy, bus.done, bus.aborted};
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL zero_outs[%0d]: got %b expected %b", idx, outs, exp);
            end
            tick();
            #1;
        end
    endtask

    // target=5, pause over cycles 4 and 5 after the start edge.
    task automatic test_pause();
        logic [7:0] exp_val [2:9];
        logic       exp_en;
        exp_val = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5};
        kick(8'd5);
        for (int idx = 1; idx <= 9; idx++) begin
            bus.pause = (idx == 4 || idx == 5);
            #1;
            exp_en = (idx >= 2 && idx <= 8 && idx != 4 && idx != 5);
            checks++;
            if (bus.cnt_en !== exp_en || bus.done !== (idx == 9)) begin
                errors++;
                $display("FAIL pause_ctl[%0d]: got en=%b done=%b expected en=%b done=%b", idx,
                         bus.cnt_en, bus.done, exp_en, (idx == 9));
            end
            if (idx >= 2) begin
                checks++;
                if (bus.cnt_value !== exp_val[idx]) begin
                    errors++;
                    $display("FAIL pause_value[%0d]: got %0d expected %0d", idx, bus.cnt_value,
                             exp_val[idx]);
                end
            end
            tick();
        end
        bus.pause = 1'b0;
    endtask

    // target=10, abort (with pause also high) in the 4th RUN cycle.
    task automatic test_abort();
        kick(8'd10);
        for (int idx = 1; idx <= 7; idx++) begin
            bus.abort = (idx == 5);
            bus.pause = (idx == 5);
            #1;
            if (idx == 5) begin
                checks++;
                if (bus.cnt_en !== 1'b0 || bus.cnt_value !== 8'd3) begin
                    errors++;
                    $display("FAIL abort_cycle: got en=%b val=%0d expected en=0 val=3",
                             bus.cnt_en, bus.cnt_value);
                end
            end
            if (idx >= 6) begin
                checks++;
                if ({bus.aborted, bus.done, bus.busy} !== {(idx == 6), 1'b0, 1'b0} ||
                    bus.cnt_value !== 8'd3) begin
                    errors++;
                    $display("FAIL abort_after[%0d]: got ab/dn/bz=%b val=%0d expected %b val=3",
                             idx, {bus.aborted, bus.done, bus.busy}, bus.cnt_value,
                             {(idx == 6), 2'b00});
                end
            end
            tick();
        end
        bus.abort = 1'b0;
        bus.pause = 1'b0;
    endtask

    // target=4; a start with target=1 mid-RUN must not disturb the job.
    task automatic test_start_ignored();
        kick(8'd4);
        for (int idx = 1; idx <= 7; idx++) begin
            bus.start  = (idx == 3);
            bus.target = (idx == 3) ? 8'd1 : 8'hA5;
            #1;
            checks++;
            if (bus.busy !== (idx <= 5) || bus.done !== (idx == 6)) begin
                errors++;
                $display("FAIL ignore_start[%0d]: got busy=%b done=%b expected busy=%b done=%b",
                         idx, bus.busy, bus.done, (idx <= 5), (idx == 6));
            end
            tick();
        end
        bus.start = 1'b0;
        checks++;
        if (bus.cnt_value !== 8'd4) begin
            errors++;
            $display("FAIL ignore_start_value: got %0d expected 4", bus.cnt_value);
        end
    endtask

    // target=3, abort on the terminal cycle (counter reads 2).
    task automatic test_abort_terminal();
        kick(8'd3);
        for (int idx = 1; idx <= 5; idx++) begin
            bus.abort = (idx == 4);
            #1;
            if (idx == 4) begin
                checks++;
                if (bus.cnt_en !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_term_en: got %b expected 0", bus.cnt_en);
                end
            end
            if (idx == 5) begin
                checks++;
                if ({bus.aborted, bus.done} !== 2'b10 || bus.cnt_value !== 8'd2) begin
                    errors++;
                    $display("FAIL abort_term: got ab/dn=%b val=%0d expected 10 val=2",
                             {bus.aborted, bus.done}, bus.cnt_value);
                end
            end
            tick();
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [4:0] outs;
        kick(8'd6);
        repeat (3) tick();
        #3;
        rst_n = 1'b0;
        #1;
        outs = {bus.cnt_en, bus.cnt_clr, bus.busy, bus.done, bus.aborted};
        checks++;
        if (outs !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", outs, 5'b0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        kick(8'd2);
        for (int idx = 1; idx <= 4; idx++) begin
            #1;
            checks++;
            if (bus.done !== (idx == 4) || bus.cnt_clr !== (idx == 1)) begin
                errors++;
                $display("FAIL post_reset_job[%0d]: got done=%b clr=%b expected done=%b clr=%b",
                         idx, bus.done, bus.cnt_clr, (idx == 4), (idx == 1));
            end
            if (idx == 4) begin
                checks++;
                if (bus.cnt_value !== 8'd2) begin
                    errors++;
                    $display("FAIL post_reset_value: got %0d expected 2", bus.cnt_value);
                end
            end
            tick();
        end
    endtask

    // target=1 then a start held through DONE: accepted only in the first IDLE cycle.
    task automatic test_back_to_back();
        kick(8'd1);
        for (int idx = 1; idx <= 8; idx++) begin
            bus.start  = (idx == 3 || idx == 4);
            bus.target = 8'd2;
            #1;
            checks++;
            if (bus.done !== (idx == 3 || idx == 8) ||
                bus.cnt_clr !== (idx == 1 || idx == 5) ||
                bus.busy !== (idx <= 2 || (idx >= 5 && idx <= 7))) begin
                errors++;
                $display("FAIL b2b[%0d]: got dn/clr/bz=%b expected %b", idx,
                         {bus.done, bus.cnt_clr, bus.busy},
                         {(idx == 3 || idx == 8), (idx == 1 || idx == 5),
                          (idx <= 2 || (idx >= 5 && idx <= 7))});
            end
            tick();
        end
        bus.start = 1'b0;
        checks++;
        if (bus.cnt_value !== 8'd2) begin
            errors++;
            $display("FAIL b2b_value: got %0d expected 2", bus.cnt_value);
        end
    endtask

    task automatic test_max_target();
        int done_idx;
        done_idx = 0;
        kick(8'd255);
        for (int idx = 1; idx <= 300 && done_idx == 0; idx++) begin
            #1;
            if (bus.done) done_idx = idx;
            else tick();
        end
        checks++;
        if (done_idx != 257) begin
            errors++;
            $display("FAIL max_latency: got %0d expected 257", done_idx);
        end
        checks++;
        if (bus.cnt_value !== 8'd255) begin
            errors++;
            $display("FAIL max_value: got %0d expected 255", bus.cnt_value);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_zero();
        test_pause();
        test_abort();
        test_start_ignored();
        test_abort_terminal();
        test_async_reset();
        test_back_to_back();
        test_max_target();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
